rr_id_alloc_ctrl: RTL and testbench

Allocation and recovery sequencer for the rename stage. It hands out INSTR_COUNT ROB ids and RHT ids per accepted rename group and generates the front-end stall. It retires ids on in-order commit and rolls both id spaces back on a misprediction recovery, holding rec_busy while the rename tables restore. Sits between decode/commit/branch-resolve and the rename unit, which consumes alloc_rob_id, alloc_rht_id, stall, rec_en and rec_busy.

---
 rtl/rr_id_alloc_ctrl_pkg.sv | 36 +++
 rtl/rr_id_alloc_ctrl_id_ring_ctr.sv | 52 +++++
 rtl/rr_id_alloc_ctrl.sv | 90 +++++++++
 tb/tb_rr_id_alloc_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_id_alloc_ctrl_pkg.sv
// Shared constants, FSM encoding and ring-pointer helpers for the rename
// id allocator. Depths need not be powers of two, so every wrap is an
// explicit compare-and-subtract.
package rr_id_alloc_ctrl_pkg;

  localparam int INSTR_COUNT_DEF = 2;
  localparam int C_NUM_DEF       = 4;
  localparam int K_DEF           = 8;
  localparam int REC_CYCLES_DEF  = 2;

  localparam int ROB_DEPTH = (C_NUM_DEF - 1) * K_DEF;
  localparam int RHT_DEPTH = C_NUM_DEF * K_DEF;
  localparam int ROB_ID_W  = $clog2(ROB_DEPTH);
  localparam int RHT_ID_W  = $clog2(RHT_DEPTH);

  typedef logic [0:0] rr_state_t;
  localparam rr_state_t ST_IDLE    = 1'b0;
  localparam rr_state_t ST_RECOVER = 1'b1;

  // ptr + n modulo depth; n never exceeds depth.
  function automatic int wrap_add(int ptr, int n, int depth);
    int s;
    s = ptr + n;
    if (s >= depth) s = s - depth;
    return s;
  endfunction

  // Distance walking forward from a to b around a ring of size depth.
  function automatic int ring_dist(int a, int b, int depth);
    int d;
    d = b - a;
    if (d < 0) d = d + depth;
    return d;
  endfunction

endpackage

// File: rtl/rr_id_alloc_ctrl_id_ring_ctr.sv
// One circular id space: head/tail/count with group allocate, in-order
// commit and rollback to a surviving id. Instantiated for ROB and RHT.
module id_ring_ctr
  import rr_id_alloc_ctrl_pkg::*;
#(
  parameter  int DEPTH = 24,
  parameter  int N     = 2,
  localparam int W     = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int NW    = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc,
  input  logic [NW-1:0]       ncm,
  input  logic                rb_en,
  input  logic [W-1:0]        rb_id,
  output logic [N-1:0][W-1:0] ids,
  output logic [CW-1:0]       free
);

  logic [W-1:0]  head;
  logic [W-1:0]  tail;
  logic [CW-1:0] cnt;

  // Ids for the pending group are consecutive from tail.
  for (genvar g = 0; g < N; g++) begin : g_ids
    assign ids[g] = W'(wrap_add(int'(tail), g, DEPTH));
  end

  assign free = CW'(DEPTH - int'(cnt));

  // Pointer/count update; rollback wins over alloc (alloc is stalled then),
  // commits retire from the head in every case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= W'(wrap_add(int'(head), int'(ncm), DEPTH));
      if (rb_en) begin
        tail <= W'(wrap_add(int'(rb_id), 1, DEPTH));
        cnt  <= CW'(ring_dist(int'(head), int'(rb_id), DEPTH) + 1 - int'(ncm));
      end else begin
        if (alloc) tail <= W'(wrap_add(int'(tail), N, DEPTH));
        cnt <= CW'(int'(cnt) - int'(ncm) + (alloc ? N : 0));
      end
    end
  end

endmodule

// File: rtl/rr_id_alloc_ctrl.sv
// Rename-stage id allocation and misprediction recovery sequencer.
// Hands out ROB/RHT ids per group, stalls the front end when either ring
// lacks room or a recovery is in flight, and rolls both rings back on rec_en.
module rr_id_alloc_ctrl
  import rr_id_alloc_ctrl_pkg::*;
#(
  parameter  int INSTR_COUNT = INSTR_COUNT_DEF,
  parameter  int C_NUM       = C_NUM_DEF,
  parameter  int K           = K_DEF,
  parameter  int REC_CYCLES  = REC_CYCLES_DEF,
  localparam int ROB_D       = (C_NUM - 1) * K,
  localparam int RHT_D       = C_NUM * K,
  localparam int ROB_W       = $clog2(ROB_D),
  localparam int RHT_W       = $clog2(RHT_D)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          inst_en,
  output logic                          stall,
  output logic [INSTR_COUNT-1:0][ROB_W-1:0] alloc_rob_id,
  output logic [INSTR_COUNT-1:0][RHT_W-1:0] alloc_rht_id,
  input  logic [INSTR_COUNT-1:0]        commit_en,
  input  logic                          rec_en,
  input  logic [ROB_W-1:0]              rec_rob_id,
  input  logic [RHT_W-1:0]              rec_rht_id,
  output logic                          rec_busy,
  output logic                          wb_allow
);

  localparam int NW  = $clog2(INSTR_COUNT + 1);
  localparam int RCW = $clog2(REC_CYCLES + 1);

  rr_state_t                  state;
  logic [RCW-1:0]             rec_ctr;
  logic [NW-1:0]              ncm;
  logic                       accept;
  logic [$clog2(ROB_D+1)-1:0] rob_free;
  logic [$clog2(RHT_D+1)-1:0] rht_free;

  // Commits are thermometer coded, so the popcount is the retire count.
  always_comb begin
    ncm = '0;
    for (int i = 0; i < INSTR_COUNT; i++) ncm = ncm + NW'(commit_en[i]);
  end

  // Room check uses pre-commit counts; a same-cycle commit never unstalls.
  assign rec_busy = (state == ST_RECOVER);
  assign stall    = rec_en | rec_busy
                  | (int'(rob_free) < INSTR_COUNT)
                  | (int'(rht_free) < INSTR_COUNT);
  assign accept   = inst_en & ~stall;
  assign wb_allow = ~(rec_en | rec_busy);

  id_ring_ctr #(.DEPTH(ROB_D), .N(INSTR_COUNT)) u_rob (
    .clk   (clk),
    .rst_n (rst_n),
    .alloc (accept),
    .ncm   (ncm),
    .rb_en (rec_en),
    .rb_id (rec_rob_id),
    .ids   (alloc_rob_id),
    .free  (rob_free)
  );

  id_ring_ctr #(.DEPTH(RHT_D), .N(INSTR_COUNT)) u_rht (
    .clk   (clk),
    .rst_n (rst_n),
    .alloc (accept),
    .ncm   (ncm),
    .rb_en (rec_en),
    .rb_id (rec_rht_id),
    .ids   (alloc_rht_id),
    .free  (rht_free)
  );

  // Recovery sequencer: each rec_en (re)starts a REC_CYCLES busy window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rec_ctr <= '0;
    end else if (rec_en) begin
      state   <= ST_RECOVER;
      rec_ctr <= RCW'(REC_CYCLES - 1);
    end else if (state == ST_RECOVER) begin
      if (rec_ctr == '0) state <= ST_IDLE;
      else               rec_ctr <= rec_ctr - 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_id_alloc_ctrl.sv
// Randomized + directed bench for rr_id_alloc_ctrl. The reference keeps the
// live ROB/RHT ids as queues: commits pop the front, recovery drops entries
// younger than the surviving id, accepts push new ids.
module tb_rr_id_alloc_ctrl;

  localparam int N  = 2;
  localparam int RD = 24;
  localparam int HD = 32;
  localparam int RC = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 inst_en;
  logic                 stall;
  logic [N-1:0][4:0]    alloc_rob_id;
  logic [N-1:0][4:0]    alloc_rht_id;
  logic [N-1:0]         commit_en;
  logic                 rec_en;
  logic [4:0]           rec_rob_id;
  logic [4:0]           rec_rht_id;
  logic                 rec_busy;
  logic                 wb_allow;

  rr_id_alloc_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_en      (inst_en),
    .stall        (stall),
    .alloc_rob_id (alloc_rob_id),
    .alloc_rht_id (alloc_rht_id),
    .commit_en    (commit_en),
    .rec_en       (rec_en),
    .rec_rob_id   (rec_rob_id),
    .rec_rht_id   (rec_rht_id),
    .rec_busy     (rec_busy),
    .wb_allow     (wb_allow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference state
  int rq[$];
  int hq[$];
  int rnext, hnext, busy_left;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    hq.delete();
    rnext = 0;
    hnext = 0;
    busy_left = 0;
  endtask

  function automatic bit exp_stall(input bit rec);
    return rec || (busy_left > 0) || (RD - rq.size() < N) || (HD - hq.size() < N);
  endfunction

  // One cycle: drive, compare at negedge, advance reference at posedge.
  task automatic cyc(input bit inst, input logic [N-1:0] cm, input bit rec,
                     input int rrob, input int rrht);
    int ncm;
    bit acc;
    ncm = 0;
    for (int i = 0; i < N; i++) ncm += int'(cm[i]);
    assert (cm == N'((1 << ncm) - 1)) else $error("non-thermometer commit_en");
    assert (ncm <= rq.size()) else $error("commit beyond occupancy");
    assert (!(rec && rq.size() == 0)) else $error("recovery with empty ROB");
    inst_en    = inst;
    commit_en  = cm;
    rec_en     = rec;
    rec_rob_id = 5'(rrob);
    rec_rht_id = 5'(rrht);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("alloc_rob_id", int'(alloc_rob_id[i]), (rnext + i) % RD);
      chk("alloc_rht_id", int'(alloc_rht_id[i]), (hnext + i) % HD);
    end
    chk("stall", int'(stall), int'(exp_stall(rec)));
    chk("rec_busy", int'(rec_busy), int'(busy_left > 0));
    chk("wb_allow", int'(wb_allow), int'(!(rec || busy_left > 0)));
    @(posedge clk);
    acc = inst && !exp_stall(rec);
    repeat (ncm) begin
      void'(rq.pop_front());
      void'(hq.pop_front());
    end
    if (rec) begin
      while (rq.size() > 0 && rq[$] != rrob) void'(rq.pop_back());
      while (hq.size() > 0 && hq[$] != rrht) void'(hq.pop_back());
      rnext = (rrob + 1) % RD;
      hnext = (rrht + 1) % HD;
      busy_left = RC;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    if (acc) begin
      for (int i = 0; i < N; i++) begin
        rq.push_back(rnext);
        hq.push_back(hnext);
        rnext = (rnext + 1) % RD;
        hnext = (hnext + 1) % HD;
      end
    end
    #1;
  endtask

  // Asynchronous reset entered away from a clock edge; outputs must clear at once.
  task automatic do_reset();
    inst_en = 0; commit_en = '0; rec_en = 0;
    rst_n = 0;
    #1;
    chk("rst rec_busy", int'(rec_busy), 0);
    chk("rst stall", int'(stall), 0);
    chk("rst wb_allow", int'(wb_allow), 1);
    for (int i = 0; i < N; i++) begin
      chk("rst rob_id", int'(alloc_rob_id[i]), i);
      chk("rst rht_id", int'(alloc_rht_id[i]), i);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    logic [N-1:0] cmv;
    int ncm, j;
    bit inst, rec;
    model_reset();
    rst_n = 0; inst_en = 0; commit_en = '0; rec_en = 0;
    rec_rob_id = '0; rec_rht_id = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Fill and wrap.
    repeat (11) cyc(1, 2'b00, 0, 0, 0);
    chk("fill g12 rob0", int'(alloc_rob_id[0]), 22);
    chk("fill g12 rob1", int'(alloc_rob_id[1]), 23);
    cyc(1, 2'b00, 0, 0, 0);
    chk("full stall", int'(stall), 1);
    cyc(1, 2'b00, 0, 0, 0);
    cyc(1, 2'b11, 0, 0, 0);
    chk("unstall", int'(stall), 0);
    chk("wrap rob0", int'(alloc_rob_id[0]), 0);
    chk("wrap rob1", int'(alloc_rob_id[1]), 1);
    chk("wrap rht0", int'(alloc_rht_id[0]), 24);
    chk("wrap rht1", int'(alloc_rht_id[1]), 25);
    do_reset();

    // Plain recovery.
    repeat (5) cyc(1, 2'b00, 0, 0, 0);
    cyc(0, 2'b00, 1, 3, 3);
    chk("rec c1 busy", int'(rec_busy), 1);
    chk("rec c1 wb", int'(wb_allow), 0);
    cyc(1, 2'b00, 0, 0, 0);
    chk("rec c2 busy", int'(rec_busy), 1);
    chk("rec c2 stall", int'(stall), 1);
    cyc(1, 2'b00, 0, 0, 0);
    chk("rec end busy", int'(rec_busy), 0);
    chk("rec end stall", int'(stall), 0);
    chk("rec end rob0", int'(alloc_rob_id[0]), 4);
    chk("rec end rob1", int'(alloc_rob_id[1]), 5);
    chk("rec cnt", int'(dut.u_rob.cnt), 4);
    do_reset();

    // Recovery with a same-cycle commit.
    repeat (5) cyc(1, 2'b00, 0, 0, 0);
    cyc(0, 2'b01, 1, 3, 3);
    chk("reccm head", int'(dut.u_rob.head), 1);
    chk("reccm cnt", int'(dut.u_rob.cnt), 3);
    cyc(0, 2'b00, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 0);
    chk("reccm rob0", int'(alloc_rob_id[0]), 4);
    chk("reccm rob1", int'(alloc_rob_id[1]), 5);
    do_reset();

    // Recovery across the ROB wrap, nested recovery, reset mid-RECOVER.
    repeat (10) cyc(1, 2'b00, 0, 0, 0);
    repeat (10) cyc(0, 2'b11, 0, 0, 0);
    repeat (5) cyc(1, 2'b00, 0, 0, 0);
    chk("xwrap cnt0", int'(dut.u_rob.cnt), 10);
    cyc(0, 2'b00, 1, 1, 25);
    chk("xwrap rob0", int'(alloc_rob_id[0]), 2);
    chk("xwrap rob1", int'(alloc_rob_id[1]), 3);
    chk("xwrap cnt", int'(dut.u_rob.cnt), 6);
    cyc(1, 2'b00, 1, 23, 23);
    chk("nest c1 busy", int'(rec_busy), 1);
    cyc(1, 2'b00, 0, 0, 0);
    chk("nest c2 busy", int'(rec_busy), 1);
    cyc(1, 2'b00, 0, 0, 0);
    chk("nest end busy", int'(rec_busy), 0);
    chk("nest rob0", int'(alloc_rob_id[0]), 0);
    chk("nest rht0", int'(alloc_rht_id[0]), 24);
    chk("nest cnt", int'(dut.u_rob.cnt), 4);
    cyc(0, 2'b00, 1, 21, 21);
    do_reset();

    // Randomized legal traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      inst = ($urandom_range(0, 3) != 0);
      ncm = $urandom_range(0, (rq.size() < N) ? rq.size() : N);
      cmv = '0;
      for (int i = 0; i < ncm; i++) cmv[i] = 1'b1;
      rec = (rq.size() > ncm) && ($urandom_range(0, 15) == 0);
      j = rec ? $urandom_range(ncm, rq.size() - 1) : 0;
      if (rec) cyc(inst, cmv, 1, rq[j], hq[j]);
      else     cyc(inst, cmv, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
